// File: rtl/r4_otf_quotient_converter.sv
// Radix-4 on-the-fly quotient converter: folds signed digits {-2..+2}
// into Q / QM registers and returns the remainder-corrected quotient.
module r4_otf_quotient_converter #(
  parameter int QUOT_W = 32,
  parameter int CNT_W  = $clog2(QUOT_W/2) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid_i,
  output logic              start_ready_o,
  input  logic [CNT_W-1:0]  iter_num_i,
  input  logic              dig_valid_i,
  output logic              dig_ready_o,
  input  logic [4:0]        quo_dig_i,
  input  logic              rem_neg_i,
  output logic              quo_valid_o,
  input  logic              quo_ready_i,
  output logic [QUOT_W-1:0] quo_o,
  output logic              err_o
);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUOT_W/2);

  state_t state_q, state_d;
  logic [QUOT_W-1:0] q_q, q_d;
  logic [QUOT_W-1:0] qm_q, qm_d;
  logic [QUOT_W-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic err_q, err_d;

  logic start_fire, dig_fire, quo_fire;
  logic one_hot, last_dig;
  logic [4:0] dig;
  logic [QUOT_W-1:0] q_nx, qm_nx;

  assign start_fire = start_valid_i && start_ready_o;
  assign dig_fire   = dig_valid_i && dig_ready_o;
  assign quo_fire   = quo_valid_o && quo_ready_i;

  // Illegal digits fall back to 0 so the Q/QM invariant survives.
  assign one_hot = (quo_dig_i != 5'd0) &&
                   ((quo_dig_i & (quo_dig_i - 5'd1)) == 5'd0);
  assign dig      = one_hot ? quo_dig_i : 5'b00100;
  assign last_dig = (cnt_q + CNT_W'(1)) == tgt_q;

  always_comb begin
    q_nx  = {q_q[QUOT_W-3:0], 2'b00};
    qm_nx = {qm_q[QUOT_W-3:0], 2'b11};
    unique case (1'b1)
      dig[4]: begin
        q_nx  = {q_q[QUOT_W-3:0], 2'b10};
        qm_nx = {q_q[QUOT_W-3:0], 2'b01};
      end
      dig[3]: begin
        q_nx  = {q_q[QUOT_W-3:0], 2'b01};
        qm_nx = {q_q[QUOT_W-3:0], 2'b00};
      end
      dig[1]: begin
        q_nx  = {qm_q[QUOT_W-3:0], 2'b11};
        qm_nx = {qm_q[QUOT_W-3:0], 2'b10};
      end
      dig[0]: begin
        q_nx  = {qm_q[QUOT_W-3:0], 2'b10};
        qm_nx = {qm_q[QUOT_W-3:0], 2'b01};
      end
      default: begin
        q_nx  = {q_q[QUOT_W-3:0], 2'b00};
        qm_nx = {qm_q[QUOT_W-3:0], 2'b11};
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    qm_d    = qm_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start_fire) begin
          state_d = ITER;
          q_d     = '0;
          qm_d    = '1;
          cnt_d   = '0;
          err_d   = 1'b0;
          tgt_d   = (iter_num_i == '0) ? FULL_CNT : iter_num_i;
        end
      end
      ITER: begin
        if (dig_fire) begin
          q_d   = q_nx;
          qm_d  = qm_nx;
          cnt_d = cnt_q + CNT_W'(1);
          err_d = err_q | ~one_hot;
          if (last_dig) begin
            state_d = DONE;
            res_d   = rem_neg_i ? qm_nx : q_nx;
          end
        end
      end
      DONE: begin
        if (quo_fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      qm_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      tgt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      qm_q    <= qm_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      err_q   <= err_d;
    end
  end

  // Held low while reset is applied so no start slips in.
  assign start_ready_o = (state_q == IDLE) && !rst;
  assign dig_ready_o   = (state_q == ITER);
  assign quo_valid_o   = (state_q == DONE);
  assign quo_o         = res_q;
  assign err_o         = err_q;

endmodule
